// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for the up/down counter.
// Build with COUNTER_SATURATE_EN defined to make counting saturate instead of wrap.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 flag;
    } step_t;

    // Operates on a MAX_WIDTH container so one function serves every legal WIDTH.
    // flag marks that the step hit the end of range (wrap, or blocked when saturating).
    function automatic step_t next_count(input logic [MAX_WIDTH-1:0] cur,
                                         input logic                 up,
                                         input int                   width);
        logic [MAX_WIDTH-1:0] top;
        logic                 at_end;
        step_t                res;
        top    = '1;
        top    = top >> (MAX_WIDTH - width);
        at_end = up ? (cur == top) : (cur == '0);
`ifdef COUNTER_SATURATE_EN
        res.value = at_end ? cur : (up ? cur + 32'd1 : cur - 32'd1);
`else
        res.value = (up ? cur + 32'd1 : cur - 32'd1) & top;
`endif
        res.flag = at_end;
        return res;
    endfunction

endpackage

// File: rtl/counter_if.sv
// Signal bundle for the counter: dut modport for the block, tb modport with a
// sampling clocking block for bench-side observation.
interface counter_if #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) (
    input logic clk,
    input logic rst
);

    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    clocking cb @(posedge clk);
        input en, clr, load, load_val, dir, count, tc, wrapped;
    endclocking

    modport dut (
        input  clk, rst, en, clr, load, load_val, dir,
        output count, tc, wrapped
    );

    modport tb (
        clocking cb,
        input  clk, rst, count, tc, wrapped,
        output en, clr, load, load_val, dir
    );

endinterface

// File: rtl/counter.sv
// Up/down binary counter with clear, load, terminal count and sticky wrap flag.
// COUNTER_SATURATE_EN (see counter_pkg) switches wrap-around to saturation.
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    counter_if.dut bus
);

    logic [WIDTH-1:0] count_reg;
    logic             wrapped_reg;
    step_t            step;
    logic             unused_step_hi;

    always_comb step = next_count(MAX_WIDTH'(count_reg), bus.dir, WIDTH);

    // Bits above WIDTH are always zero by construction.
    assign unused_step_hi = ^(step.value >> WIDTH);

    always_ff @(posedge bus.clk) begin
        if (!bus.rst) begin
            count_reg   <= RESET_VAL;
            wrapped_reg <= 1'b0;
        end else if (bus.clr) begin
            count_reg   <= RESET_VAL;
            wrapped_reg <= 1'b0;
        end else if (bus.load) begin
            count_reg   <= bus.load_val;
        end else if (bus.en) begin
            count_reg   <= step.value[WIDTH-1:0];
            if (step.flag) begin
                wrapped_reg <= 1'b1;
            end
        end
    end

    assign bus.count   = count_reg;
    assign bus.wrapped = wrapped_reg;
    assign bus.tc      = bus.dir ? (count_reg == '1) : (count_reg == '0);

endmodule

// File: tb/tb_counter.sv
// Randomized scoreboard bench for counter against an integer reference model.
module tb_counter;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int    cnt;
        bit    tc;
        bit    wr;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   txn;
    int   m_cnt;
    bit   m_wr;
    exp_t sb[$];

    counter_if #(.WIDTH(W)) cif (.clk(clk), .rst(rst));

    counter #(.WIDTH(W), .RESET_VAL(8'h00)) dut (.bus(cif));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit tc_of(input bit d, input int c);
        return d ? (c == MAXV) : (c == 0);
    endfunction

    task automatic model_step(input bit r, c, l, input int lv, input bit e, d);
        if (!r || c) begin
            m_cnt = 0;
            m_wr  = 1'b0;
        end else if (l) begin
            m_cnt = lv;
        end else if (e) begin
            if (d && m_cnt == MAXV) begin
                m_wr = 1'b1;
`ifndef COUNTER_SATURATE_EN
                m_cnt = 0;
`endif
            end else if (!d && m_cnt == 0) begin
                m_wr = 1'b1;
`ifndef COUNTER_SATURATE_EN
                m_cnt = MAXV;
`endif
            end else begin
                m_cnt = d ? m_cnt + 1 : m_cnt - 1;
            end
        end
    endtask

    task automatic drive(input bit r, c, l, input int lv, input bit e, d, input string tag);
        exp_t x;
        @(negedge clk);
        rst          = r;
        cif.clr      = c;
        cif.load     = l;
        cif.load_val = W'(lv);
        cif.en       = e;
        cif.dir      = d;
        model_step(r, c, l, lv, e, d);
        x.cnt = m_cnt;
        x.tc  = tc_of(d, m_cnt);
        x.wr  = m_wr;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Monitor: every edge the DUT presents a fresh count; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d %s count=%02h tc=%0b wrapped=%0b", txn, e.tag,
                         cif.count, cif.tc, cif.wrapped);
                checks++;
                if (cif.count !== W'(e.cnt)) begin
                    errors++;
                    $display("FAIL %s.count got %02h want %02h", e.tag, cif.count, W'(e.cnt));
                end
                checks++;
                if (cif.tc !== e.tc) begin
                    errors++;
                    $display("FAIL %s.tc got %0b want %0b", e.tag, cif.tc, e.tc);
                end
                checks++;
                if (cif.wrapped !== e.wr) begin
                    errors++;
                    $display("FAIL %s.wrapped got %0b want %0b", e.tag, cif.wrapped, e.wr);
                end
            end
        end
    end

    initial begin
        bit d_r;
        errors = 0;
        checks = 0;
        txn    = 0;
        m_cnt  = 0;
        m_wr   = 1'b0;
        rst          = 1'b0;
        cif.clr      = 1'b0;
        cif.load     = 1'b0;
        cif.load_val = '0;
        cif.en       = 1'b1;
        cif.dir      = 1'b0;

        repeat (2) drive(0, 0, 0, 0, 1, 0, "reset");
        drive(1, 0, 0, 0, 0, 1, "rst_tc_up");
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 1, 1, "enable");
        repeat (3) drive(1, 0, 0, 0, 0, 1, "hold");

        drive(1, 0, 1, 'hFE, 0, 1, "load_fe");
        repeat (3) drive(1, 0, 0, 0, 1, 1, "up_wrap");
        drive(1, 0, 0, 0, 0, 1, "wrap_sticky");

        drive(1, 1, 0, 0, 0, 1, "clr");
        drive(1, 0, 1, 'h01, 0, 0, "load_01");
        repeat (3) drive(1, 0, 0, 0, 1, 0, "down_wrap");

        drive(1, 1, 1, 'h55, 1, 1, "prio_clr");
        drive(1, 0, 1, 'h55, 1, 1, "prio_load");

        drive(1, 0, 0, 0, 1, 1, "dir_up");
        drive(1, 0, 0, 0, 1, 0, "dir_down");
        drive(1, 0, 0, 0, 1, 0, "dir_down");
        drive(1, 0, 0, 0, 1, 1, "dir_up");

        drive(1, 0, 1, 36, 0, 1, "load_36");
        drive(1, 0, 0, 0, 1, 1, "to_37");
        drive(0, 0, 0, 0, 1, 1, "mid_rst");
        drive(1, 0, 0, 0, 1, 1, "resume");

        d_r = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int lv;
            if ($urandom_range(0, 7) == 0) d_r = ~d_r;
            case ($urandom_range(0, 3))
                0:       lv = 'hFE;
                1:       lv = 'h01;
                default: lv = int'($urandom_range(0, MAXV));
            endcase
            drive($urandom_range(0, 29) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0, lv, $urandom_range(0, 3) != 0, d_r, "rand");
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
